// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the processing-element partial-sum logic.
//   - drain_state_t : encoding of the psum drain state machine
//   - PSUM_DATA_WIDTH, SAT_MAX, SAT_MIN : default stored-psum width and its
//     signed saturation limits (two's complement bit patterns)
// ---------------------------------------------------------------------------
package pe_pkg;

   localparam int PSUM_DATA_WIDTH = 16;

   localparam logic [PSUM_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(PSUM_DATA_WIDTH-1){1'b1}}};
   localparam logic [PSUM_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(PSUM_DATA_WIDTH-1){1'b0}}};

   // Gray-ordered so that every legal transition flips a single bit.
   typedef enum logic [1:0] {
      DRAIN_IDLE = 2'b00,
      DRAIN_RD   = 2'b01,
      DRAIN_OUT  = 2'b11,
      DRAIN_DONE = 2'b10
   } drain_state_t;

endpackage

// File: rtl/psum_sat.sv
// ---------------------------------------------------------------------------
// psum_sat
// Combinational signed saturator from OUT_DATA_WIDTH down to DATA_WIDTH.
// Ports:
//   din  : signed MAC result, OUT_DATA_WIDTH bits
//   dout : din clamped to the signed DATA_WIDTH range
// ---------------------------------------------------------------------------
module psum_sat
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH     = PSUM_DATA_WIDTH,
   parameter int OUT_DATA_WIDTH = 36
) (
   input  logic signed [OUT_DATA_WIDTH-1:0] din,
   output logic        [DATA_WIDTH-1:0]     dout
);

   // Saturation limits sign-extended to the input width for comparison.
   localparam logic signed [OUT_DATA_WIDTH-1:0] MAX_EXT =
      {{(OUT_DATA_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_DATA_WIDTH-1:0] MIN_EXT =
      {{(OUT_DATA_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   always_comb begin
      dout = din[DATA_WIDTH-1:0];
      if (din > MAX_EXT) begin
         dout = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (din < MIN_EXT) begin
         dout = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end
   end

endmodule

// File: rtl/psum_pad_ctrl.sv
// ---------------------------------------------------------------------------
// psum_pad_ctrl
// Per-PE partial-sum scratchpad with a streaming drain engine.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   Para_filter_num    : active channel count N (0 means 2**OFPAD_WIDTH)
//   psum_store_flag    : store saturated accum_out into entry cnt_b
//   cnt_b              : channel address for store and read
//   accum_out          : signed MAC result
//   internal_psum      : registered read of entry cnt_b (0 if entry empty)
//   drain_start        : pulse to stream entries 0..N-1
//   dout_valid/ready   : stream handshake
//   dout_data          : stream word
//   dout_last          : marks entry N-1
//   drain_busy         : drain engine active
//   drain_done         : one-cycle pulse after the last handshake
//   store_conflict     : one-cycle pulse, a store arrived during a drain
// ---------------------------------------------------------------------------
module psum_pad_ctrl
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int OUT_DATA_WIDTH = 36,
   parameter int OFPAD_WIDTH    = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic        [OFPAD_WIDTH-1:0]    Para_filter_num,
   input  logic                             psum_store_flag,
   input  logic        [OFPAD_WIDTH-1:0]    cnt_b,
   input  logic signed [OUT_DATA_WIDTH-1:0] accum_out,
   output logic        [DATA_WIDTH-1:0]     internal_psum,
   input  logic                             drain_start,
   output logic                             dout_valid,
   input  logic                             dout_ready,
   output logic        [DATA_WIDTH-1:0]     dout_data,
   output logic                             dout_last,
   output logic                             drain_busy,
   output logic                             drain_done,
   output logic                             store_conflict
);

   localparam int DEPTH = 2**OFPAD_WIDTH;

   drain_state_t state_reg, state_next;

   logic [DATA_WIDTH-1:0]  pad_mem [DEPTH];
   logic [DEPTH-1:0]       valid_reg;
   logic [OFPAD_WIDTH-1:0] ptr_reg;
   logic [OFPAD_WIDTH-1:0] n_reg;
   logic [OFPAD_WIDTH-1:0] last_ptr;
   logic [DATA_WIDTH-1:0]  sat_val;
   logic [DATA_WIDTH-1:0]  rd_word;
   logic [DATA_WIDTH-1:0]  ptr_word;
   logic [DATA_WIDTH-1:0]  internal_psum_reg;
   logic [DATA_WIDTH-1:0]  dout_data_reg;
   logic                   dout_valid_reg;
   logic                   dout_last_reg;
   logic                   store_conflict_reg;
   logic                   fwd_ptr;
   logic                   handshake;

   // One saturator feeds the pad write, the internal_psum forward and the
   // drain forward: all three only ever need the value being stored now.
   psum_sat #(
      .DATA_WIDTH     (DATA_WIDTH),
      .OUT_DATA_WIDTH (OUT_DATA_WIDTH)
   ) u_sat (
      .din  (accum_out),
      .dout (sat_val)
   );

   // Pad data carries no reset; emptiness is tracked by valid_reg.
   always_ff @(posedge clk) begin
      if (psum_store_flag) begin
         pad_mem[cnt_b] <= sat_val;
      end
   end

   // N-1 in OFPAD_WIDTH bits; N=0 wraps to the all-ones last index.
   assign last_ptr  = n_reg - 1'b1;

   // Store and read share cnt_b, so a store always forwards to the read.
   assign rd_word   = psum_store_flag ? sat_val
                    : (valid_reg[cnt_b] ? pad_mem[cnt_b] : '0);
   assign fwd_ptr   = psum_store_flag && (cnt_b == ptr_reg);
   assign ptr_word  = fwd_ptr ? sat_val
                    : (valid_reg[ptr_reg] ? pad_mem[ptr_reg] : '0);
   assign handshake = dout_valid_reg && dout_ready;

   // Drain FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= DRAIN_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Drain FSM next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         DRAIN_IDLE: if (drain_start) state_next = DRAIN_RD;
         DRAIN_RD:   state_next = DRAIN_OUT;
         DRAIN_OUT:  if (handshake) state_next = dout_last_reg ? DRAIN_DONE : DRAIN_RD;
         DRAIN_DONE: state_next = DRAIN_IDLE;
         default:    state_next = DRAIN_IDLE;
      endcase
   end

   // Datapath: valid bits, read port, stream registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg          <= '0;
         ptr_reg            <= '0;
         n_reg              <= '0;
         internal_psum_reg  <= '0;
         dout_data_reg      <= '0;
         dout_valid_reg     <= 1'b0;
         dout_last_reg      <= 1'b0;
         store_conflict_reg <= 1'b0;
      end else begin
         internal_psum_reg  <= rd_word;
         store_conflict_reg <= psum_store_flag && (state_reg != DRAIN_IDLE);

         case (state_reg)
            DRAIN_IDLE: begin
               if (drain_start) begin
                  ptr_reg <= '0;
                  n_reg   <= Para_filter_num;
               end
            end
            DRAIN_RD: begin
               dout_data_reg  <= ptr_word;
               dout_last_reg  <= (ptr_reg == last_ptr);
               dout_valid_reg <= 1'b1;
            end
            DRAIN_OUT: begin
               // Drop valid after each accepted word so the stale word is
               // never presented twice while the next entry is fetched.
               if (handshake) begin
                  dout_valid_reg <= 1'b0;
                  dout_last_reg  <= 1'b0;
                  if (!dout_last_reg) begin
                     ptr_reg <= ptr_reg + 1'b1;
                  end
               end
            end
            default: ;
         endcase

         // Reading an entry empties it; a store in the same cycle wins.
         if (state_reg == DRAIN_RD) begin
            valid_reg[ptr_reg] <= 1'b0;
         end
         if (psum_store_flag) begin
            valid_reg[cnt_b] <= 1'b1;
         end
      end
   end

   assign internal_psum  = internal_psum_reg;
   assign dout_data      = dout_data_reg;
   assign dout_valid     = dout_valid_reg;
   assign dout_last      = dout_last_reg;
   assign store_conflict = store_conflict_reg;
   assign drain_busy     = (state_reg != DRAIN_IDLE);
   assign drain_done     = (state_reg == DRAIN_DONE);

endmodule
